// File: rtl/nibble_parity_rx_if.sv
// Serial-line bundle between the nibble receiver and its consumer.
// master drives the line; slave (the receiver) reports frames.
interface nibble_parity_rx_if;
  logic       in;
  logic       done;
  logic [3:0] data;
  logic       perr;
  logic [7:0] err_count;

  modport master (
    output in,
    input  done,
    input  data,
    input  perr,
    input  err_count
  );

  modport slave (
    input  in,
    output done,
    output data,
    output perr,
    output err_count
  );
endinterface

// File: rtl/nibble_parity_rx.sv
// Framed nibble receiver: start, 4 data (MSB first), odd parity, stop.
// NIBBLE_PARITY_RX_ERR_COUNT_EN enables the saturating parity-error count.
module nibble_parity_rx (
  input  logic               clk,
  input  logic               resetn,
  nibble_parity_rx_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE,
    S_WAIT
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] shreg_q, shreg_d;
  logic       par_q, par_d;
  logic       done_q, done_d;
  logic [3:0] data_q, data_d;
  logic       perr_q, perr_d;
  logic       exp_par;

  // parity bit the downstream stage computes for the shifted nibble
  assign exp_par = ~(^shreg_q);

  // frame sequencing and next-value computation for registered outputs
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    done_d  = 1'b0;
    data_d  = data_q;
    perr_d  = perr_q;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.in) begin
          state_d = S_DATA;
          idx_d   = 2'd0;
        end
      end
      S_DATA: begin
        shreg_d = {shreg_q[2:0], bus.in};
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        par_d   = bus.in;
        state_d = S_STOP;
      end
      S_STOP: begin
        if (bus.in) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          data_d  = shreg_q;
          perr_d  = (par_q != exp_par);
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        if (!bus.in) begin
          state_d = S_DATA;
          idx_d   = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.in) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      shreg_q <= 4'h0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= 4'h0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      done_q  <= done_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
    end
  end

  assign bus.done = done_q;
  assign bus.data = data_q;
  assign bus.perr = perr_q;

`ifdef NIBBLE_PARITY_RX_ERR_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  // count reported parity errors, sticking at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (done_d && perr_d && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // error counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.err_count = cnt_q;
`else
  assign bus.err_count = 8'h00;
`endif

  a_done_pulse: assert property (
    @(posedge clk) disable iff (!resetn)
    done_q |=> !done_q
  );

endmodule

// File: tb/tb_nibble_parity_rx.sv
// Scoreboard bench for nibble_parity_rx.
// Honours NIBBLE_PARITY_RX_ERR_COUNT_EN for err_count expectations.
module tb_nibble_parity_rx;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  // edge counter used to time done pulses
  always @(posedge clk) cyc <= cyc + 1;

  nibble_parity_rx_if bus();

  nibble_parity_rx dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0] data;
    logic       perr;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_data;
  logic       m_perr;
  logic [7:0] m_cnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: every done pulse must match the oldest expected frame
  always @(negedge clk) begin
    exp_t e;
    if (resetn === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want none (cyc %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cyc", cyc, e.cyc);
        chk("data", {28'd0, bus.data}, {28'd0, e.data});
        chk("perr", {31'd0, bus.perr}, {31'd0, e.perr});
        chk("err_count", {24'd0, bus.err_count}, {24'd0, e.cnt});
      end
    end
  end

  task automatic send_bit(input logic b);
    bus.in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [3:0] d, input logic p,
                       input logic stop, input logic exp_perr);
    exp_t e;
    if (stop) begin
      m_data = d;
      m_perr = exp_perr;
`ifdef NIBBLE_PARITY_RX_ERR_COUNT_EN
      if (exp_perr && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
`endif
      e.data = m_data;
      e.perr = m_perr;
      e.cnt  = m_cnt;
      e.cyc  = cyc + 7;
      sb.push_back(e);
    end
    send_bit(1'b0);
    for (int i = 3; i >= 0; i--) send_bit(d[i]);
    send_bit(p);
    send_bit(stop);
  endtask

  task automatic chk_held(input string nm);
    chk({nm, "_data"}, {28'd0, bus.data}, {28'd0, m_data});
    chk({nm, "_perr"}, {31'd0, bus.perr}, {31'd0, m_perr});
    chk({nm, "_cnt"}, {24'd0, bus.err_count}, {24'd0, m_cnt});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] sat;
    bus.in = 1'b1;
    resetn = 1'b0;
    m_data = 4'h0;
    m_perr = 1'b0;
    m_cnt  = 8'h00;

    for (int i = 0; i < 3; i++) begin
      bus.in = i[0];
      @(negedge clk);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_data", {28'd0, bus.data}, 32'd0);
      chk("rst_perr", {31'd0, bus.perr}, 32'd0);
      chk("rst_cnt", {24'd0, bus.err_count}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.in = 1'b1;
    resetn = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);

    frame(4'b1011, 1'b0, 1'b1, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    chk_held("good");

    frame(4'b1011, 1'b1, 1'b1, 1'b1);
    send_bit(1'b1);
    chk_held("badpar");

    frame(4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (5) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    chk_held("framerr");
    frame(4'b0000, 1'b1, 1'b1, 1'b0);
    send_bit(1'b1);
    chk_held("after_framerr");

    frame(4'b0110, 1'b1, 1'b1, 1'b0);
    frame(4'b0111, 1'b1, 1'b1, 1'b1);
    frame(4'b0111, 1'b0, 1'b1, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);

    repeat (260) frame(4'b1011, 1'b1, 1'b1, 1'b1);
    repeat (3) send_bit(1'b1);
`ifdef NIBBLE_PARITY_RX_ERR_COUNT_EN
    sat = 8'hFF;
`else
    sat = 8'h00;
`endif
    chk("sat_cnt", {24'd0, bus.err_count}, {24'd0, sat});
    chk("sat_perr", {31'd0, bus.perr}, 32'd1);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk("abort_cnt", {24'd0, bus.err_count}, 32'd0);
    chk("abort_data", {28'd0, bus.data}, 32'd0);
    chk("abort_perr", {31'd0, bus.perr}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    m_data = 4'h0;
    m_perr = 1'b0;
    m_cnt  = 8'h00;
    bus.in = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (10) send_bit(1'b1);
    chk_held("post_abort");

    frame(4'b1011, 1'b0, 1'b1, 1'b0);
    repeat (3) send_bit(1'b1);
    chk_held("recover");

    chk("pending", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_parity_rx.md
# nibble_parity_rx

- Serial receiver that assembles one framed nibble from a single-bit line:
  - start bit, four data bits, one parity bit, stop bit.
- Presents the nibble as `data[3:0]`, with `data[3]:data[0]` mapping to the parity stage's a,b,c,d inputs.
- Checks the received parity bit against that stage's function, q = ~a^b^c^d (odd parity over data plus parity bit), and flags mismatches.
- Sits directly upstream of the parity stage and feeds it; it replaces free-running a,b,c,d stimulus with framed, validated nibbles.

## Interface
- No parameters (frame format fixed: 1 start, 4 data, 1 parity, 1 stop).
- `clk`  input  1  rising-edge clock; line sampled once per cycle.
- `resetn`  input  1  asynchronous, active-low reset.
- `in`  input  1  serial line; idle high.
- `done`  output  1  one-cycle pulse: frame with valid stop bit received.
- `data`  output  4  received nibble; first data bit lands in `data[3]` (a), last in `data[0]` (d).
- `perr`  output  1  parity mismatch for the frame reported by `done`.
- `err_count`  output  8  saturating count of frames reported with `perr`=1.

## Operation
States:
- IDLE
  - `in`=0 → DATA (bit index 0).
  - Otherwise stay.
- DATA
  - Shift `in` into the nibble, MSB first.
  - After the 4th bit → PARITY.
- PARITY
  - Capture `in` as p → STOP.
- STOP
  - `in`=1 → DONE.
  - `in`=0 → WAIT.
- DONE
  - `done`=1 for this cycle.
  - `in`=0 → DATA (back-to-back start).
  - Otherwise → IDLE.
- WAIT (framing error)
  - No `done`.
  - Stay until `in`=1, then → IDLE.

Outputs:
- `perr` = (p != ~(d3^d2^d1^d0)). It is registered on entry to DONE only.
- `data` and `perr` update only on entry to DONE. They hold their values until the next DONE.
- `err_count` increments by 1 on entry to DONE when `perr`=1, saturating at 8'hFF (no wrap).
- Framing-error frames (WAIT) do not change `data`, `perr` or `err_count`.

## Timing
- Reset values: state IDLE, `done`=0, `data`=4'h0, `perr`=0, `err_count`=8'h00.
- Reset is asynchronous; asserting it mid-frame aborts the frame with no `done` and no count change.
- Cycle numbering, relative to the start bit sampled at cycle 0:
  - data bits at cycles 1–4;
  - parity at cycle 5;
  - stop at cycle 6;
  - `done`=1 during cycle 7, with `data`/`perr`/`err_count` already updated in that cycle.
- Latency: 7 cycles from the start-bit sample to `done`.
- Back-to-back frames: the next start bit may be sampled in cycle 7, giving a minimum frame period of 7 cycles.
- `done` is never high in two consecutive cycles.

## Configuration
- Macro: `NIBBLE_PARITY_RX_ERR_COUNT_EN`.
- Defined: `err_count` is implemented as described above.
- Undefined:
  - the counter is removed;
  - `err_count` is tied to 8'h00;
  - `done`, `data` and `perr` behaviour is unchanged.

## Test plan
- Reset: hold `resetn`=0 for 3 cycles with `in` toggling → `done`=0, `data`=0, `perr`=0, `err_count`=0 throughout.
- Good frame, line bits 0,1,0,1,1,0,1 (start, data 1011, parity 0, stop) → `done` pulse in cycle 7, `data`=4'b1011, `perr`=0, `err_count`=0.
- Bad parity, same frame but parity bit 1 → `done`=1 at cycle 7, `data`=4'b1011, `perr`=1, `err_count`=1.
- Framing error, frame 0,0,0,0,0,1,0 then `in`=0 for 5 cycles, then `in`=1 → no `done` and outputs unchanged. A following good frame (data 0000, parity 1) gives `done` with `data`=0, `perr`=0.
- Back-to-back: two frames with the second start bit in cycle 7 → two `done` pulses exactly 7 cycles apart.
- Saturation and reset:
  - 260 bad-parity frames → `err_count`=8'hFF, held.
  - Async `resetn` pulse in the middle of the next frame → `err_count`=0 immediately and no `done` for the aborted frame.
  - With the macro undefined → `err_count`=0 throughout.
